axi_master_bridge: RTL and testbench



---
 rtl/axi_master_bridge.sv | 198 +++++++++++++++++++
 tb/tb_axi_master_bridge.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_bridge.sv
// Single-outstanding AXI4-lite master: turns one core request into one AXI
// read or write transaction and returns a one-cycle response pulse.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_STRB_WIDTH
`define AXI_STRB_WIDTH (`AXI_DATA_WIDTH/8)
`endif
`ifndef OKAY
`define OKAY 2'b00
`endif

module axi_master_bridge (
  input  logic                       ACLK,
  input  logic                       ARESET,
  // core side
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [`AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [`AXI_DATA_WIDTH-1:0] req_wdata,
  input  logic [`AXI_STRB_WIDTH-1:0] req_strb,
  output logic                       rsp_valid,
  output logic [`AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic                       rsp_err,
  // write address channel
  output logic                       AWVALID,
  output logic [`AXI_ADDR_WIDTH-1:0] AWADDR,
  output logic [2:0]                 AWPROT,
  input  logic                       AWREADY,
  // write data channel
  output logic                       WVALID,
  output logic [`AXI_DATA_WIDTH-1:0] WDATA,
  output logic [`AXI_STRB_WIDTH-1:0] WSTRB,
  input  logic                       WREADY,
  // write response channel
  input  logic                       BVALID,
  input  logic [1:0]                 BRESP,
  output logic                       BREADY,
  // read address channel
  output logic                       ARVALID,
  output logic [`AXI_ADDR_WIDTH-1:0] ARADDR,
  output logic [2:0]                 ARPROT,
  input  logic                       ARREADY,
  // read data channel
  input  logic                       RVALID,
  input  logic [`AXI_DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]                 RRESP,
  output logic                       RREADY,
  // FSM state for checkers
  output logic [2:0]                 dbg_state
);

  // Handshake rule on every channel: a transfer happens on the rising edge
  // where VALID and READY are both high; the source holds VALID and payload
  // unchanged until then. req_valid/req_ready follow the same rule.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   aw_done, w_done;
  logic   aw_done_d, w_done_d;
  logic   aw_valid_d, w_valid_d, ar_valid_d, b_ready_d, r_ready_d;
  logic   rsp_valid_d, rsp_err_d;
  logic [`AXI_ADDR_WIDTH-1:0] awaddr_d, araddr_d;
  logic [`AXI_DATA_WIDTH-1:0] wdata_d, rsp_rdata_d;
  logic [`AXI_STRB_WIDTH-1:0] wstrb_d;

  assign req_ready = (state_q == IDLE);
  assign AWPROT    = 3'b000;
  assign ARPROT    = 3'b000;
  assign dbg_state = state_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      AWVALID   <= 1'b0;
      WVALID    <= 1'b0;
      ARVALID   <= 1'b0;
      BREADY    <= 1'b0;
      RREADY    <= 1'b0;
      AWADDR    <= '0;
      ARADDR    <= '0;
      WDATA     <= '0;
      WSTRB     <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      AWVALID   <= aw_valid_d;
      WVALID    <= w_valid_d;
      ARVALID   <= ar_valid_d;
      BREADY    <= b_ready_d;
      RREADY    <= r_ready_d;
      AWADDR    <= awaddr_d;
      ARADDR    <= araddr_d;
      WDATA     <= wdata_d;
      WSTRB     <= wstrb_d;
      aw_done   <= aw_done_d;
      w_done    <= w_done_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    aw_valid_d  = AWVALID;
    w_valid_d   = WVALID;
    ar_valid_d  = ARVALID;
    b_ready_d   = BREADY;
    r_ready_d   = RREADY;
    awaddr_d    = AWADDR;
    araddr_d    = ARADDR;
    wdata_d     = WDATA;
    wstrb_d     = WSTRB;
    aw_done_d   = aw_done;
    w_done_d    = w_done;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          awaddr_d = req_addr;
          araddr_d = req_addr;
          wdata_d  = req_wdata;
          wstrb_d  = req_strb;
          if (req_write) begin
            state_d    = WR_REQ;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
          end else begin
            state_d    = RD_REQ;
            ar_valid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        // AW and W complete independently, in either order or together.
        if (AWVALID && AWREADY) begin
          aw_done_d  = 1'b1;
          aw_valid_d = 1'b0;
        end
        if (WVALID && WREADY) begin
          w_done_d  = 1'b1;
          w_valid_d = 1'b0;
        end
        if (aw_done_d && w_done_d) begin
          state_d   = WR_RESP;
          b_ready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (BVALID && BREADY) begin
          state_d     = IDLE;
          b_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = (BRESP != `OKAY);
        end
      end
      RD_REQ: begin
        if (ARVALID && ARREADY) begin
          state_d    = RD_RESP;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end
      end
      RD_RESP: begin
        if (RVALID && RREADY) begin
          state_d     = IDLE;
          r_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = RDATA;
          rsp_err_d   = (RRESP != `OKAY);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_master_bridge.sv
// Directed bench for axi_master_bridge: the bench plays the AXI slave and the
// core, cycle by cycle, with hand-computed expectations.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_STRB_WIDTH
`define AXI_STRB_WIDTH (`AXI_DATA_WIDTH/8)
`endif

module tb_axi_master_bridge;
  localparam int AW = `AXI_ADDR_WIDTH;
  localparam int DW = `AXI_DATA_WIDTH;
  localparam int SW = `AXI_STRB_WIDTH;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_strb;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [2:0]    AWPROT, ARPROT;
  logic [DW-1:0] WDATA, RDATA;
  logic [SW-1:0] WSTRB;
  logic [1:0]    BRESP, RRESP;
  logic [2:0]    dbg_state;
  logic [4:0]    chan;

  int tests_run = 0;
  int tests_failed = 0;
  logic [DW-1:0] exp_q[$];

  assign chan = {AWVALID, WVALID, ARVALID, BREADY, RREADY};

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;

  axi_master_bridge dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .AWVALID(AWVALID), .AWADDR(AWADDR), .AWPROT(AWPROT), .AWREADY(AWREADY),
    .WVALID(WVALID), .WDATA(WDATA), .WSTRB(WSTRB), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
    .ARVALID(ARVALID), .ARADDR(ARADDR), .ARPROT(ARPROT), .ARREADY(ARREADY),
    .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY),
    .dbg_state(dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge ACLK);
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
    AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
    BVALID = 1'b0; BRESP = 2'b00; RVALID = 1'b0; RRESP = 2'b00; RDATA = '0;
  endtask

  task automatic set_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_strb = s;
  endtask

  // Slave that is always ready and always has a response pending.
  task automatic set_auto_slave(input logic [1:0] resp, input logic [DW-1:0] rdata);
    AWREADY = 1'b1; WREADY = 1'b1; ARREADY = 1'b1;
    BVALID = 1'b1; BRESP = resp; RVALID = 1'b1; RRESP = resp; RDATA = rdata;
  endtask

  // Called at a negedge with the bridge idle; returns the response it sees.
  task automatic do_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, output logic got, output logic err,
                         output logic [DW-1:0] rdata);
    got = 1'b0; err = 1'b0; rdata = '0;
    set_req(wr, a, d, s);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin
        got = 1'b1; err = rsp_err; rdata = rsp_rdata;
        break;
      end
      step();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ARESET = 1'b1;
    idle_inputs();
    step(); step();
    tests_run++; if (chan !== 5'b00000) begin tests_failed++; $display("FAIL reset_chan got=%b exp=%b", chan, 5'b00000); end
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    tests_run++; if ({rsp_valid, rsp_err} !== 2'b00) begin tests_failed++; $display("FAIL reset_rsp got=%b exp=00", {rsp_valid, rsp_err}); end
    tests_run++; if (rsp_rdata !== '0) begin tests_failed++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    tests_run++; if ({AWADDR, ARADDR, WDATA, WSTRB} !== '0) begin tests_failed++; $display("FAIL reset_payload got=%h/%h/%h/%h exp=0", AWADDR, ARADDR, WDATA, WSTRB); end
    tests_run++; if ({AWPROT, ARPROT} !== 6'b0) begin tests_failed++; $display("FAIL reset_prot got=%b exp=0", {AWPROT, ARPROT}); end
    tests_run++; if (dbg_state !== 3'd0) begin tests_failed++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    ARESET = 1'b0;
    step();
  endtask

  task automatic test_read();
    set_req(1'b0, 32'h24, 32'h0, 4'h0);
    ARREADY = 1'b1;
    step();  // cycle 1
    req_valid = 1'b0;
    tests_run++; if (chan !== 5'b00100) begin tests_failed++; $display("FAIL rd_chan_c1 got=%b exp=%b", chan, 5'b00100); end
    tests_run++; if ({ARADDR, ARPROT} !== {32'h24, 3'b000}) begin tests_failed++; $display("FAIL rd_araddr got=%h exp=24", ARADDR); end
    tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL rd_req_ready_busy got=%b exp=0", req_ready); end
    step();  // cycle 2
    tests_run++; if (chan !== 5'b00001) begin tests_failed++; $display("FAIL rd_chan_c2 got=%b exp=%b", chan, 5'b00001); end
    step();  // cycle 3
    RVALID = 1'b1; RDATA = 32'h1234_5678; RRESP = 2'b00;
    tests_run++; if ({chan, rsp_valid} !== 6'b000010) begin tests_failed++; $display("FAIL rd_wait_c3 got=%b exp=%b", {chan, rsp_valid}, 6'b000010); end
    step();  // cycle 4
    RVALID = 1'b0; RDATA = '0;
    tests_run++; if ({rsp_valid, rsp_err} !== 2'b10) begin tests_failed++; $display("FAIL rd_rsp got=%b exp=10", {rsp_valid, rsp_err}); end
    tests_run++; if (rsp_rdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL rd_rdata got=%h exp=12345678", rsp_rdata); end
    tests_run++; if (chan !== 5'b00000) begin tests_failed++; $display("FAIL rd_chan_done got=%b exp=0", chan); end
    step();  // cycle 5
    tests_run++; if ({rsp_valid, rsp_rdata} !== {1'b0, 32'h1234_5678}) begin tests_failed++; $display("FAIL rd_hold got=%b/%h exp=0/12345678", rsp_valid, rsp_rdata); end
    idle_inputs();
  endtask

  task automatic test_read_slverr();
    logic got, err;
    logic [DW-1:0] rd;
    set_auto_slave(2'b10, 32'hCAFE_F00D);
    do_xfer(1'b0, 32'h30, 32'h0, 4'h0, got, err, rd);
    tests_run++; if ({got, err} !== 2'b11) begin tests_failed++; $display("FAIL slverr_err got=%b exp=11", {got, err}); end
    tests_run++; if (rd !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL slverr_rdata got=%h exp=cafef00d", rd); end
    idle_inputs();
    step();
  endtask

  // Follows the SLVERR read, so it also shows the error and read data clearing.
  task automatic test_write_basic();
    set_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    AWREADY = 1'b1; WREADY = 1'b1;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL wr_req_ready_c0 got=%b exp=1", req_ready); end
    step();  // cycle 1
    req_valid = 1'b0;
    tests_run++; if (chan !== 5'b11000) begin tests_failed++; $display("FAIL wr_chan_c1 got=%b exp=%b", chan, 5'b11000); end
    tests_run++; if ({AWADDR, WDATA, WSTRB} !== {32'h10, 32'hDEAD_BEEF, 4'hF}) begin tests_failed++; $display("FAIL wr_payload got=%h/%h/%h exp=10/deadbeef/f", AWADDR, WDATA, WSTRB); end
    step();  // cycle 2
    BVALID = 1'b1; BRESP = 2'b00;
    tests_run++; if ({chan, rsp_valid} !== 6'b000100) begin tests_failed++; $display("FAIL wr_chan_c2 got=%b exp=%b", {chan, rsp_valid}, 6'b000100); end
    step();  // cycle 3
    BVALID = 1'b0;
    tests_run++; if ({rsp_valid, rsp_err, req_ready} !== 3'b101) begin tests_failed++; $display("FAIL wr_rsp_c3 got=%b exp=101", {rsp_valid, rsp_err, req_ready}); end
    tests_run++; if (rsp_rdata !== '0) begin tests_failed++; $display("FAIL wr_rdata_zero got=%h exp=0", rsp_rdata); end
    step();  // cycle 4
    tests_run++; if ({rsp_valid, chan} !== 6'b0) begin tests_failed++; $display("FAIL wr_after got=%b exp=0", {rsp_valid, chan}); end
    idle_inputs();
  endtask

  task automatic test_write_aw_delay();
    set_req(1'b1, 32'h40, 32'h0BAD_F00D, 4'h3);
    WREADY = 1'b1;
    BVALID = 1'b1; BRESP = 2'b00;  // early B must be ignored until BREADY
    step();
    req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tests_run++; if ({AWVALID, AWADDR} !== {1'b1, 32'h40}) begin tests_failed++; $display("FAIL awd_aw_hold_c%0d got=%b/%h exp=1/40", i, AWVALID, AWADDR); end
      tests_run++; if ({WVALID, BREADY, rsp_valid} !== ((i == 1) ? 3'b100 : 3'b000)) begin tests_failed++; $display("FAIL awd_w_b_c%0d got=%b exp=%b", i, {WVALID, BREADY, rsp_valid}, ((i == 1) ? 3'b100 : 3'b000)); end
      if (i == 4) AWREADY = 1'b1;
      step();
    end
    AWREADY = 1'b0;  // cycle 5
    tests_run++; if ({chan, rsp_valid} !== 6'b000100) begin tests_failed++; $display("FAIL awd_bready got=%b exp=%b", {chan, rsp_valid}, 6'b000100); end
    step();  // cycle 6
    BVALID = 1'b0;
    tests_run++; if ({rsp_valid, rsp_err} !== 2'b10) begin tests_failed++; $display("FAIL awd_rsp got=%b exp=10", {rsp_valid, rsp_err}); end
    step();
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL awd_single_rsp got=%b exp=0", rsp_valid); end
    idle_inputs();
  endtask

  task automatic test_reset_in_wr_resp();
    logic got, err;
    logic [DW-1:0] rd;
    set_req(1'b1, 32'h80, 32'h1111_2222, 4'hF);
    AWREADY = 1'b1; WREADY = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    tests_run++; if (chan !== 5'b00010) begin tests_failed++; $display("FAIL rst_pre_chan got=%b exp=%b", chan, 5'b00010); end
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    BVALID = 1'b1;  // stale response after the abort
    tests_run++; if ({chan, rsp_valid} !== 6'b0) begin tests_failed++; $display("FAIL rst_outputs got=%b exp=0", {chan, rsp_valid}); end
    tests_run++; if ({req_ready, dbg_state} !== 4'b1000) begin tests_failed++; $display("FAIL rst_idle got=%b/%0d exp=1/0", req_ready, dbg_state); end
    step();
    BVALID = 1'b0;
    tests_run++; if ({chan, rsp_valid} !== 6'b0) begin tests_failed++; $display("FAIL rst_no_rsp got=%b exp=0", {chan, rsp_valid}); end
    set_auto_slave(2'b00, 32'h5555_AAAA);
    do_xfer(1'b0, 32'h84, 32'h0, 4'h0, got, err, rd);
    tests_run++; if ({got, err, rd} !== {2'b10, 32'h5555_AAAA}) begin tests_failed++; $display("FAIL rst_then_read got=%b%b/%h exp=10/5555aaaa", got, err, rd); end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    logic          wr_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [DW-1:0] auto_rd = 32'hA5A5_0001;
    logic [DW-1:0] exp;
    int idx = 0, accepts = 0, resp_cnt = 0, overlap = 0, same_cycle = 0, last_rsp = -1;
    logic accepting;
    set_auto_slave(2'b00, auto_rd);
    set_req(wr_seq[0], 32'h100, 32'h1000, 4'hF);
    for (int cyc = 0; cyc < 40 && resp_cnt < 4; cyc++) begin
      if ((AWVALID || WVALID) && ARVALID) overlap++;
      if (rsp_valid) begin
        resp_cnt++;
        last_rsp = cyc;
        if (req_ready) same_cycle++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL b2b_extra_rsp got=%h exp=none", rsp_rdata);
        end else begin
          exp = exp_q.pop_front();
          if (rsp_rdata !== exp) begin tests_failed++; $display("FAIL b2b_rsp%0d got=%h exp=%h", resp_cnt, rsp_rdata, exp); end
        end
      end
      accepting = req_ready && (idx < 4);
      if (accepting) begin
        exp_q.push_back(wr_seq[idx] ? '0 : auto_rd);
        accepts++;
      end
      step();
      if (accepting) begin
        idx++;
        if (idx < 4) set_req(wr_seq[idx], 32'h100 + 32'(4 * idx), 32'h1000 + 32'(idx), 4'hF);
        else req_valid = 1'b0;
      end
    end
    tests_run++; if ({accepts, resp_cnt} !== {32'd4, 32'd4}) begin tests_failed++; $display("FAIL b2b_counts got=%0d/%0d exp=4/4", accepts, resp_cnt); end
    tests_run++; if (overlap !== 0) begin tests_failed++; $display("FAIL b2b_overlap got=%0d exp=0", overlap); end
    tests_run++; if (last_rsp !== 12) begin tests_failed++; $display("FAIL b2b_last_rsp_cycle got=%0d exp=12", last_rsp); end
    tests_run++; if (same_cycle !== 4) begin tests_failed++; $display("FAIL b2b_ready_with_rsp got=%0d exp=4", same_cycle); end
    tests_run++; if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL b2b_pending got=%0d exp=0", exp_q.size()); end
    idle_inputs();
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_read();
    test_read_slverr();
    test_write_basic();
    test_write_aw_delay();
    test_reset_in_wr_resp();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
